// File: rtl/dmx_slot_buffer.sv
// Double-buffered DMX universe store: the host fills the back bank, the transmitter
// pulls start code + channel bytes from the active bank, banks swap only at frame_start.
module dmx_slot_buffer #(
  parameter int          NUM_SLOTS  = 512,
  parameter int          ADDR_W     = 9,
  parameter logic [7:0]  START_CODE = 8'h00
) (
  input  logic              dmxclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              commit,
  input  logic              frame_start,
  input  logic              slot_req,
  output logic              slot_valid,
  output logic [7:0]        slot_data,
  output logic              slot_last,
  output logic              commit_pending,
  output logic              active_bank,
  output logic              wr_drop,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVING = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int               PTR_W   = ADDR_W + 1;
  localparam int               IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(NUM_SLOTS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_accept;
  logic             w_is_last;
  logic             w_wr_ok;
  logic             w_swap;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  logic [7:0]       r_bank0 [NUM_SLOTS];
  logic [7:0]       r_bank1 [NUM_SLOTS];
  logic [7:0]       r_rd0;
  logic [7:0]       r_rd1;
  logic             r_rd_sel;
  logic             r_rd_start;
  logic             r_valid;
  logic             r_last;
  logic             r_pending;
  logic             r_active;
  logic             r_drop;

  assign w_wr_ok   = {1'b0, wr_addr} < LP_LAST;
  assign w_wr_idx  = IDX_W'(wr_addr);
  assign w_is_last = (r_ptr == LP_LAST);
  // Slot n carries channel n-1; the slot-0 read result is unused (start code wins).
  assign w_rd_idx  = IDX_W'(r_ptr - PTR_W'(1));
  assign w_swap    = frame_start & (r_pending | commit);

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_accept    = 1'b0;
    if (frame_start) begin
      w_state_nxt = ST_SERVING;
      w_ptr_nxt   = '0;
    end else if (r_state == ST_SERVING && slot_req) begin
      w_accept  = 1'b1;
      w_ptr_nxt = r_ptr + PTR_W'(1);
      if (w_is_last) begin
        w_state_nxt = ST_DONE;
      end
    end
  end

  always_ff @(posedge dmxclk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rd_start <= 1'b0;
      r_pending  <= 1'b0;
      r_active   <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_valid    <= w_accept;
      r_last     <= w_accept & w_is_last;
      r_rd_sel   <= r_active;
      r_rd_start <= (r_ptr == '0);
      if (w_swap) begin
        r_active  <= ~r_active;
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
      if (wr_en && !w_wr_ok) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Host writes go to the bank not being transmitted, so each bank keeps a single write port.
  always_ff @(posedge dmxclk) begin
    if (wr_en && w_wr_ok && r_active) begin
      r_bank0[w_wr_idx] <= wr_data;
    end
    r_rd0 <= r_bank0[w_rd_idx];
  end

  always_ff @(posedge dmxclk) begin
    if (wr_en && w_wr_ok && !r_active) begin
      r_bank1[w_wr_idx] <= wr_data;
    end
    r_rd1 <= r_bank1[w_rd_idx];
  end

  always_comb begin
    slot_data = 8'h00;
    if (r_valid) begin
      if (r_rd_start) begin
        slot_data = START_CODE;
      end else begin
        slot_data = r_rd_sel ? r_rd1 : r_rd0;
      end
    end
  end

  assign slot_valid     = r_valid;
  assign slot_last      = r_last;
  assign commit_pending = r_pending;
  assign active_bank    = r_active;
  assign wr_drop        = r_drop;
  assign dbg_state      = r_state;

endmodule
